// File: rtl/trig_pkg.sv
// Shared definitions for the FWU command-slot scheduler.
//  - mode1 type codes driven into the command builder
//  - FSM state encoding
//  - lowest_lane(): index of the lowest set bit of a 4-lane keep mask
package trig_pkg;

  localparam logic [1:0] MODE1_NOOP = 2'd0;
  localparam logic [1:0] MODE1_FWU  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTES = 2'd1,
    MARK  = 2'd2,
    GAP   = 2'd3
  } fwu_state_t;

  // Lane 0 has the highest priority. An empty mask yields lane 0.
  function automatic logic [1:0] lowest_lane(input logic [3:0] keep);
    logic [1:0] lane;
    lane = 2'd0;
    if (keep[0]) begin
      lane = 2'd0;
    end else if (keep[1]) begin
      lane = 2'd1;
    end else if (keep[2]) begin
      lane = 2'd2;
    end else if (keep[3]) begin
      lane = 2'd3;
    end else begin
      lane = 2'd0;
    end
    return lane;
  endfunction

endpackage

// File: rtl/trig_fwu_byte_unpacker.sv
// Holds one 32-bit FWU word and its keep mask, and hands its bytes out lowest lane first.
// Ports:
//  clk, rst      clock and synchronous active-high reset (drops the held word)
//  clear         drop the held lanes (flush)
//  load          capture load_data / load_keep
//  advance       retire the lowest remaining lane
//  empty         no lanes remain in the held word
//  empty_next    no lanes will remain after this cycle's load/advance/clear
//  byte_next     byte of the lowest lane that will be held after this cycle
// The "_next" outputs let the parent register its outputs from post-update contents.
module trig_fwu_byte_unpacker
  import trig_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [3:0]  load_keep,
  input  logic        advance,
  output logic        empty,
  output logic        empty_next,
  output logic [7:0]  byte_next
);

  logic [31:0] data_q;
  logic [31:0] data_d;
  logic [3:0]  keep_q;
  logic [3:0]  keep_d;
  logic [1:0]  lane_next;

  // Next word/mask: clear beats load beats advance.
  always_comb begin
    data_d = data_q;
    keep_d = keep_q;
    if (clear) begin
      keep_d = 4'd0;
    end else if (load) begin
      data_d = load_data;
      keep_d = load_keep;
    end else if (advance) begin
      // keep & (keep - 1) clears exactly the lowest set lane
      keep_d = keep_q & (keep_q - 4'd1);
    end else begin
      keep_d = keep_q;
    end
  end

  // Word and mask storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= 32'd0;
      keep_q <= 4'd0;
    end else begin
      data_q <= data_d;
      keep_q <= keep_d;
    end
  end

  assign lane_next  = lowest_lane(keep_d);
  assign byte_next  = data_d[{lane_next, 3'b000} +: 8];
  assign empty      = (keep_q == 4'd0);
  assign empty_next = (keep_d == 4'd0);

endmodule

// File: rtl/trig_fwu_scheduler.sv
// Sequences FWU stream bytes into the mode1 field of the command word, one byte per
// command slot, inserting a bank mark after each block and a NOOP gap after the mark.
// Ports:
//  sysclk_i, sysclk_rst_i      clock and synchronous active-high reset
//  sysclk_phase_i              command slot strobe (builder samples mode1 on it)
//  enable_i                    allow a new word to be accepted
//  flush_i                     abort the current block
//  s_fwu_*                     AXI4-Stream input of 32-bit words with byte keep
//  mode1type_o / mode1data_o   registered slot content (NOOP, FWU byte or mark)
//  busy_o, bank_o              status: not idle / bank the next mark carries
//  bytes_sent_o, marks_sent_o  wrapping consume counters
module trig_fwu_scheduler
  import trig_pkg::*;
#(
  parameter int MARK_GAP   = 4,
  parameter     SYSCLKTYPE = "NONE"
) (
  input  logic        sysclk_i,
  input  logic        sysclk_rst_i,
  input  logic        sysclk_phase_i,
  input  logic        enable_i,
  input  logic        flush_i,
  input  logic [31:0] s_fwu_tdata,
  input  logic [3:0]  s_fwu_tkeep,
  input  logic        s_fwu_tlast,
  input  logic        s_fwu_tvalid,
  output logic        s_fwu_tready,
  output logic [1:0]  mode1type_o,
  output logic [7:0]  mode1data_o,
  output logic        busy_o,
  output logic        bank_o,
  output logic [31:0] bytes_sent_o,
  output logic [15:0] marks_sent_o
);

  fwu_state_t  state_r, state_n;
  logic [7:0]  gap_r, gap_n;
  logic        bank_r, bank_n;
  logic        last_r, last_n;
  logic [31:0] bytes_r;
  logic [15:0] marks_r;
  logic [1:0]  mode1type_r, type_n;
  logic [7:0]  mode1data_r, data_n;
  logic        tready_r, tready_n;
  logic        accept, load, advance, byte_inc, mark_inc;
  logic        empty, empty_next;
  logic [7:0]  byte_next;

  // tready is only ever registered high for a cycle whose state is IDLE
  assign accept = s_fwu_tvalid && tready_r;

  trig_fwu_byte_unpacker u_unpacker (
    .clk        (sysclk_i),
    .rst        (sysclk_rst_i),
    .clear      (flush_i),
    .load       (load),
    .load_data  (s_fwu_tdata),
    .load_keep  (s_fwu_tkeep),
    .advance    (advance),
    .empty      (empty),
    .empty_next (empty_next),
    .byte_next  (byte_next)
  );

  // Next-state logic plus the values the output registers take on the next edge.
  always_comb begin
    state_n  = state_r;
    gap_n    = gap_r;
    bank_n   = bank_r;
    last_n   = last_r;
    load     = 1'b0;
    advance  = 1'b0;
    byte_inc = 1'b0;
    mark_inc = 1'b0;
    if (flush_i) begin
      state_n = IDLE;
      gap_n   = 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept) begin
            load   = 1'b1;
            last_n = s_fwu_tlast;
            if (s_fwu_tkeep != 4'd0) begin
              state_n = BYTES;
            end else if (s_fwu_tlast) begin
              state_n = MARK;
            end else begin
              state_n = IDLE;
            end
          end else begin
            state_n = IDLE;
          end
        end
        BYTES: begin
          if (empty) begin
            state_n = last_r ? MARK : IDLE;
          end else if (sysclk_phase_i) begin
            advance  = 1'b1;
            byte_inc = 1'b1;
            if (empty_next) begin
              state_n = last_r ? MARK : IDLE;
            end else begin
              state_n = BYTES;
            end
          end else begin
            state_n = BYTES;
          end
        end
        MARK: begin
          if (sysclk_phase_i) begin
            bank_n   = ~bank_r;
            mark_inc = 1'b1;
            if (MARK_GAP == 0) begin
              state_n = IDLE;
            end else begin
              gap_n   = 8'(MARK_GAP);
              state_n = GAP;
            end
          end else begin
            state_n = MARK;
          end
        end
        GAP: begin
          if (sysclk_phase_i) begin
            if (gap_r <= 8'd1) begin
              gap_n   = 8'd0;
              state_n = IDLE;
            end else begin
              gap_n   = gap_r - 8'd1;
              state_n = GAP;
            end
          end else begin
            state_n = GAP;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end

    case (state_n)
      BYTES: begin
        type_n = MODE1_FWU;
        data_n = byte_next;
      end
      MARK: begin
        type_n = MODE1_NOOP;
        data_n = {6'b000000, 1'b1, bank_n};
      end
      default: begin
        type_n = MODE1_NOOP;
        data_n = 8'd0;
      end
    endcase
    tready_n = (state_n == IDLE) && enable_i;
  end

  // State, counters and registered outputs.
  always_ff @(posedge sysclk_i) begin
    if (sysclk_rst_i) begin
      state_r     <= IDLE;
      gap_r       <= 8'd0;
      bank_r      <= 1'b0;
      last_r      <= 1'b0;
      bytes_r     <= 32'd0;
      marks_r     <= 16'd0;
      mode1type_r <= MODE1_NOOP;
      mode1data_r <= 8'd0;
      tready_r    <= 1'b0;
    end else begin
      state_r     <= state_n;
      gap_r       <= gap_n;
      bank_r      <= bank_n;
      last_r      <= last_n;
      bytes_r     <= bytes_r + {31'd0, byte_inc};
      marks_r     <= marks_r + {15'd0, mark_inc};
      mode1type_r <= type_n;
      mode1data_r <= data_n;
      tready_r    <= tready_n;
    end
  end

  assign s_fwu_tready = tready_r;
  assign mode1type_o  = mode1type_r;
  assign mode1data_o  = mode1data_r;

  // Status outputs: direct in the local domain, one extra retiming stage when tagged
  // for a clock crossing so the far side sees them straight from flops.
  generate
    if (SYSCLKTYPE == "NONE") begin : g_status_direct
      assign busy_o       = (state_r != IDLE);
      assign bank_o       = bank_r;
      assign bytes_sent_o = bytes_r;
      assign marks_sent_o = marks_r;
    end else begin : g_status_retimed
      logic        busy_q;
      logic        bank_q;
      logic [31:0] bytes_q;
      logic [15:0] marks_q;
      // Retiming stage for status leaving the domain.
      always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i) begin
          busy_q  <= 1'b0;
          bank_q  <= 1'b0;
          bytes_q <= 32'd0;
          marks_q <= 16'd0;
        end else begin
          busy_q  <= (state_r != IDLE);
          bank_q  <= bank_r;
          bytes_q <= bytes_r;
          marks_q <= marks_r;
        end
      end
      assign busy_o       = busy_q;
      assign bank_o       = bank_q;
      assign bytes_sent_o = bytes_q;
      assign marks_sent_o = marks_q;
    end
  endgenerate

endmodule

// File: tb/tb_trig_fwu_scheduler.sv
// Bench for trig_fwu_scheduler: directed block scenarios followed by randomized traffic,
// all checked against a slot-queue reference model.
module tb_trig_fwu_scheduler;

  localparam int MARK_GAP  = 4;
  localparam int SLOT_MARK = 256;
  localparam int SLOT_GAP  = 257;

  logic        sysclk_i = 1'b0;
  logic        sysclk_rst_i = 1'b1;
  logic        sysclk_phase_i = 1'b0;
  logic        enable_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] s_fwu_tdata = 32'd0;
  logic [3:0]  s_fwu_tkeep = 4'd0;
  logic        s_fwu_tlast = 1'b0;
  logic        s_fwu_tvalid = 1'b0;
  logic        s_fwu_tready;
  logic [1:0]  mode1type_o;
  logic [7:0]  mode1data_o;
  logic        busy_o;
  logic        bank_o;
  logic [31:0] bytes_sent_o;
  logic [15:0] marks_sent_o;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: every slot the block still owes, in order.
  // 0..255 = FWU byte, SLOT_MARK = bank mark, SLOT_GAP = forced NOOP slot.
  int          q[$];
  logic        m_bank = 1'b0;
  logic [31:0] m_bytes = 32'd0;
  logic [15:0] m_marks = 16'd0;
  logic        m_tready = 1'b0;

  trig_fwu_scheduler #(.MARK_GAP(MARK_GAP), .SYSCLKTYPE("NONE")) dut (
    .sysclk_i       (sysclk_i),
    .sysclk_rst_i   (sysclk_rst_i),
    .sysclk_phase_i (sysclk_phase_i),
    .enable_i       (enable_i),
    .flush_i        (flush_i),
    .s_fwu_tdata    (s_fwu_tdata),
    .s_fwu_tkeep    (s_fwu_tkeep),
    .s_fwu_tlast    (s_fwu_tlast),
    .s_fwu_tvalid   (s_fwu_tvalid),
    .s_fwu_tready   (s_fwu_tready),
    .mode1type_o    (mode1type_o),
    .mode1data_o    (mode1data_o),
    .busy_o         (busy_o),
    .bank_o         (bank_o),
    .bytes_sent_o   (bytes_sent_o),
    .marks_sent_o   (marks_sent_o)
  );

  always #5 sysclk_i = ~sysclk_i;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare every observable output against the model.
  task automatic check_outputs();
    logic [1:0] e_type;
    logic [7:0] e_data;
    e_type = 2'd0;
    e_data = 8'd0;
    if (q.size() != 0) begin
      if (q[0] < 256) begin
        e_type = 2'd3;
        e_data = 8'(q[0]);
      end else if (q[0] == SLOT_MARK) begin
        e_data = {6'b000000, 1'b1, m_bank};
      end
    end
    check_value("mode1type", {30'd0, mode1type_o}, {30'd0, e_type});
    check_value("mode1data", {24'd0, mode1data_o}, {24'd0, e_data});
    check_value("busy", {31'd0, busy_o}, {31'd0, (q.size() != 0)});
    check_value("tready", {31'd0, s_fwu_tready}, {31'd0, m_tready});
    check_value("bank", {31'd0, bank_o}, {31'd0, m_bank});
    check_value("bytes_sent", bytes_sent_o, m_bytes);
    check_value("marks_sent", {16'd0, marks_sent_o}, {16'd0, m_marks});
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge,
  // check at the next falling edge.
  task automatic tick(input logic ph, input logic fl, input logic rs);
    logic acc;
    int   e;
    sysclk_phase_i = ph;
    flush_i        = fl;
    sysclk_rst_i   = rs;
    acc = s_fwu_tvalid && m_tready;
    @(posedge sysclk_i);
    if (rs) begin
      q.delete();
      m_bank  = 1'b0;
      m_bytes = 32'd0;
      m_marks = 16'd0;
    end else if (fl) begin
      q.delete();
    end else begin
      if (ph && q.size() != 0) begin
        e = q.pop_front();
        if (e < 256) begin
          m_bytes = m_bytes + 32'd1;
        end else if (e == SLOT_MARK) begin
          m_marks = m_marks + 16'd1;
          m_bank  = ~m_bank;
        end
      end
      if (acc) begin
        for (int i = 0; i < 4; i++) begin
          if (s_fwu_tkeep[i]) q.push_back(int'(s_fwu_tdata[i*8 +: 8]));
        end
        if (s_fwu_tlast) begin
          q.push_back(SLOT_MARK);
          for (int i = 0; i < MARK_GAP; i++) q.push_back(SLOT_GAP);
        end
      end
    end
    m_tready = !rs && (q.size() == 0) && enable_i;
    @(negedge sysclk_i);
    check_outputs();
    if (acc) s_fwu_tvalid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l);
    s_fwu_tdata  = d;
    s_fwu_tkeep  = k;
    s_fwu_tlast  = l;
    s_fwu_tvalid = 1'b1;
    for (int i = 0; i < 20 && s_fwu_tvalid; i++) tick(1'b0, 1'b0, 1'b0);
    check_value("accept_timeout", {31'd0, s_fwu_tvalid}, 32'd0);
    s_fwu_tvalid = 1'b0;
  endtask

  task automatic run_slots(input int n);
    for (int s = 0; s < n; s++) begin
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int ph_cnt;
    @(negedge sysclk_i);
    enable_i = 1'b1;
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);

    // plain word, no mark
    send_word(32'h44332211, 4'hF, 1'b0);
    run_slots(5);
    // block end: mark 0x02, gap, then a second block with mark 0x03
    send_word(32'h44332211, 4'hF, 1'b1);
    run_slots(10);
    check_value("bank_after_mark", {31'd0, bank_o}, 32'd1);
    send_word(32'h44332211, 4'hF, 1'b1);
    run_slots(10);
    // sparse keep
    send_word(32'hDDCCBBAA, 4'b1010, 1'b0);
    run_slots(3);
    check_value("bytes_after_sparse", bytes_sent_o, 32'd14);
    // empty word carrying only tlast
    send_word(32'h12345678, 4'b0000, 1'b1);
    run_slots(6);
    check_value("marks_after_empty", {16'd0, marks_sent_o}, 32'd3);
    // flush after two bytes of a last word
    send_word(32'h88776655, 4'hF, 1'b1);
    run_slots(2);
    tick(1'b0, 1'b1, 1'b0);
    run_slots(2);
    check_value("bank_after_flush", {31'd0, bank_o}, 32'd1);
    check_value("marks_after_flush", {16'd0, marks_sent_o}, 32'd3);
    // reset in the middle of a word, then a clean restart
    send_word(32'hA4A3A2A1, 4'hF, 1'b0);
    run_slots(1);
    tick(1'b0, 1'b0, 1'b1);
    check_value("bytes_after_reset", bytes_sent_o, 32'd0);
    send_word(32'hB4B3B2B1, 4'hF, 1'b1);
    run_slots(10);

    // randomized traffic
    ph_cnt = 3;
    for (int c = 0; c < 4000; c++) begin
      logic ph;
      if (!s_fwu_tvalid && ($urandom % 3 == 0)) begin
        s_fwu_tdata  = $urandom;
        s_fwu_tkeep  = 4'($urandom % 16);
        s_fwu_tlast  = 1'($urandom % 2);
        s_fwu_tvalid = 1'b1;
      end
      enable_i = ($urandom % 8) != 0;
      ph = 1'b0;
      if (ph_cnt == 0) begin
        ph = 1'b1;
        ph_cnt = $urandom_range(3, 6);
      end else begin
        ph_cnt--;
      end
      tick(ph, 1'(($urandom % 64) == 0), 1'(($urandom % 700) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
